// File: rtl/jump_resolve_unit_pkg.sv
// Shared constants, jump-type and FSM state enums for the jump resolve unit.
// The optional return-address stack is enabled with the JUMP_RAS_EN macro.
package jump_pkg;

   localparam logic [5:0] OP_J        = 6'b000010;
   localparam logic [5:0] OP_JAL      = 6'b000011;
   localparam logic [5:0] FN_JR       = 6'b001000;
   localparam logic [5:0] FN_JALR     = 6'b001001;
   localparam logic [2:0] ALUOP_RTYPE = 3'b011;

   typedef enum logic [2:0] {JT_NONE, JT_J, JT_JAL, JT_JR, JT_JALR} jump_t;
   typedef enum logic [1:0] {IDLE, WAIT_RS, RESOLVE} state_t;

   // R-type funct decode takes precedence; real R-type words carry opcode 0.
   function automatic jump_t decode_jump(input logic is_rtype,
                                         input logic [5:0] opcode,
                                         input logic [5:0] funct);
      if (is_rtype && funct == FN_JR)   return JT_JR;
      if (is_rtype && funct == FN_JALR) return JT_JALR;
      if (opcode == OP_J)               return JT_J;
      if (opcode == OP_JAL)             return JT_JAL;
      return JT_NONE;
   endfunction

endpackage

// File: rtl/jump_resolve_unit_if.sv
// ID-stage jump bus: decoded instruction in, stall/flush/redirect out, plus debug taps.
// Handshake: i_valid offers an instruction; while o_stall is high upstream holds it, and
// it is consumed in the cycle o_stall is low again (the redirect cycle).
interface jump_resolve_unit_if #(
   parameter int PC_W      = 32,
   parameter int DATA_W    = 32,
   parameter int ALUOP_W   = 3,
   parameter int RAS_DEPTH = 8
);
   import jump_pkg::*;

   logic               i_valid;
   logic [ALUOP_W-1:0] i_AluOp;
   logic [5:0]         i_opcode;
   logic [5:0]         i_Function_code;
   logic               i_rs_is_ra;
   logic [DATA_W-1:0]  i_rs_value;
   logic               i_rs_ready;
   logic [25:0]        i_jump_index;
   logic [PC_W-1:0]    i_pc_plus4;

   logic               o_JR_Control;
   logic               o_JALR_Control;
   logic               o_link;
   logic [PC_W-1:0]    o_link_addr;
   logic               o_stall;
   logic               o_flush;
   logic               o_target_valid;
   logic [PC_W-1:0]    o_target;
   logic               o_misaligned;
   logic               o_mispredict;
   logic               o_timeout;

   state_t                           dbg_state;
   logic [$clog2(RAS_DEPTH+1)-1:0]   dbg_ras_count;
   logic                             dbg_ras_full;

   modport master (
      output i_valid, i_AluOp, i_opcode, i_Function_code, i_rs_is_ra,
             i_rs_value, i_rs_ready, i_jump_index, i_pc_plus4,
      input  o_JR_Control, o_JALR_Control, o_link, o_link_addr, o_stall, o_flush,
             o_target_valid, o_target, o_misaligned, o_mispredict, o_timeout,
             dbg_state, dbg_ras_count, dbg_ras_full
   );

   modport slave (
      input  i_valid, i_AluOp, i_opcode, i_Function_code, i_rs_is_ra,
             i_rs_value, i_rs_ready, i_jump_index, i_pc_plus4,
      output o_JR_Control, o_JALR_Control, o_link, o_link_addr, o_stall, o_flush,
             o_target_valid, o_target, o_misaligned, o_mispredict, o_timeout,
             dbg_state, dbg_ras_count, dbg_ras_full
   );

endinterface

// File: rtl/jump_resolve_unit_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
// Used by jump_resolve_unit only when JUMP_RAS_EN is defined.
module return_addr_stack #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           push_data,
   output logic [WIDTH-1:0]           top,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    ptr_q;
   logic [CW-1:0]    count_q;

   assign top   = mem[ptr_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));
   assign count = count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else if (push && !pop) begin
         ptr_q <= ptr_q + PW'(1);
         if (!full) count_q <= count_q + CW'(1);
      end else if (pop && !push && !empty) begin
         ptr_q   <= ptr_q - PW'(1);
         count_q <= count_q - CW'(1);
      end
   end

   // Storage carries no reset; count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push && pop)  mem[ptr_q] <= push_data;
      else if (push)    mem[ptr_q + PW'(1)] <= push_data;
   end

endmodule

// File: rtl/jump_resolve_unit.sv
// Resolves J/JAL/JR/JALR in ID: stalls until rs is final, then issues a one-cycle redirect.
// Define JUMP_RAS_EN to add return-address-stack prediction of JR $ra targets.
module jump_resolve_unit
   import jump_pkg::*;
#(
   parameter int PC_W      = 32,
   parameter int DATA_W    = 32,
   parameter int ALUOP_W   = 3,
   parameter int RAS_DEPTH = 8,
   parameter int MAX_WAIT  = 15
) (
   input logic               i_clk,
   input logic               i_reset,
   jump_resolve_unit_if.slave bus
);
   localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

   state_t            state_q, state_d;
   jump_t             jt_in, jt_q;
   logic [PC_W-1:0]   pc4_q;
   logic [25:0]       idx_q;
   logic [DATA_W-1:0] rs_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              timeout_q;
   logic              accept, reg_in, reg_q, match;
   logic [PC_W-1:0]   rs_tgt, pred_q;
   logic              pred_valid_q, spec_q;

   logic              stall, flush, tv, jr_c, jalr_c, link, mis, mispred;
   logic [PC_W-1:0]   target, link_addr;

   assign jt_in  = decode_jump(bus.i_AluOp == ALUOP_W'(ALUOP_RTYPE), bus.i_opcode,
                               bus.i_Function_code);
   assign reg_in = (jt_in == JT_JR) || (jt_in == JT_JALR);
   assign reg_q  = (jt_q == JT_JR) || (jt_q == JT_JALR);
   assign accept = (state_q == IDLE) && bus.i_valid && (jt_in != JT_NONE);
   assign rs_tgt = {rs_q[PC_W-1:2], 2'b00};
   assign match  = pred_valid_q && (rs_tgt == pred_q);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= IDLE;
         jt_q      <= JT_NONE;
         pc4_q     <= '0;
         idx_q     <= '0;
         rs_q      <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            jt_q  <= jt_in;
            pc4_q <= bus.i_pc_plus4;
            idx_q <= bus.i_jump_index;
            if (bus.i_rs_ready) rs_q <= bus.i_rs_value;
         end
         // WAIT_RS leaves on the first ready cycle, so rs is captured exactly once.
         if (state_q == WAIT_RS) begin
            if (bus.i_rs_ready) begin
               rs_q <= bus.i_rs_value;
            end else if (cnt_q != CNT_MAX) begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_MAX - CNT_W'(1)) timeout_q <= 1'b1;
            end
         end
         if (state_q == RESOLVE) cnt_q <= '0;
      end
   end

   always_comb begin
      state_d   = state_q;
      stall     = 1'b0;
      flush     = 1'b0;
      tv        = 1'b0;
      target    = '0;
      jr_c      = 1'b0;
      jalr_c    = 1'b0;
      link      = 1'b0;
      link_addr = '0;
      mis       = 1'b0;
      mispred   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               stall   = 1'b1;
               state_d = (reg_in && !bus.i_rs_ready) ? WAIT_RS : RESOLVE;
            end
         end
         WAIT_RS: begin
            stall = 1'b1;
            if (spec_q) begin
               tv     = 1'b1;
               flush  = 1'b1;
               target = pred_q;
            end
            if (bus.i_rs_ready) state_d = RESOLVE;
         end
         RESOLVE: begin
            state_d   = IDLE;
            jr_c      = reg_q;
            jalr_c    = (jt_q == JT_JALR);
            link      = (jt_q == JT_JAL) || (jt_q == JT_JALR);
            link_addr = pc4_q;
            target    = reg_q ? rs_tgt : {pc4_q[PC_W-1:28], idx_q, 2'b00};
            mis       = reg_q && (rs_q[1:0] != 2'b00);
            // A confirmed prediction already redirected the front end.
            tv        = !match;
            flush     = !match;
            mispred   = pred_valid_q && !match;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef JUMP_RAS_EN
   logic            ras_push, ras_pop, ras_empty, spec_hit;
   logic [PC_W-1:0] ras_top;

   assign ras_pop  = accept && bus.i_rs_is_ra && !ras_empty &&
                     (((jt_in == JT_JR) && !bus.i_rs_ready) || (jt_in == JT_JALR));
   assign spec_hit = ras_pop && !bus.i_rs_ready;
   assign ras_push = (state_q == RESOLVE) && ((jt_q == JT_JAL) || (jt_q == JT_JALR));

   return_addr_stack #(.DEPTH(RAS_DEPTH), .WIDTH(PC_W)) u_ras (
      .clk       (i_clk),
      .rst       (i_reset),
      .push      (ras_push),
      .pop       (ras_pop),
      .push_data (pc4_q),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (bus.dbg_ras_full),
      .count     (bus.dbg_ras_count)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pred_valid_q <= 1'b0;
         spec_q       <= 1'b0;
         pred_q       <= '0;
      end else begin
         if (accept) begin
            pred_valid_q <= spec_hit;
            spec_q       <= spec_hit;
            pred_q       <= ras_top;
         end else if (state_q == WAIT_RS) begin
            spec_q <= 1'b0;
         end
         if (state_q == RESOLVE) pred_valid_q <= 1'b0;
      end
   end
`else
   assign pred_valid_q      = 1'b0;
   assign spec_q            = 1'b0;
   assign pred_q            = '0;
   assign bus.dbg_ras_count = '0;
   assign bus.dbg_ras_full  = 1'b0;
`endif

   assign bus.o_stall        = stall;
   assign bus.o_flush        = flush;
   assign bus.o_target_valid = tv;
   assign bus.o_target       = target;
   assign bus.o_JR_Control   = jr_c;
   assign bus.o_JALR_Control = jalr_c;
   assign bus.o_link         = link;
   assign bus.o_link_addr    = link_addr;
   assign bus.o_misaligned   = mis;
   assign bus.o_mispredict   = mispred;
   assign bus.o_timeout      = timeout_q;
   assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_jump_resolve_unit.sv
// Self-checking bench for jump_resolve_unit: vector table, timeout, reset abort and,
// when JUMP_RAS_EN is defined, return-address-stack prediction sequences.
`timescale 1ns/1ps
module tb_jump_resolve_unit;
   import jump_pkg::*;

   localparam int PC_W      = 32;
   localparam int DATA_W    = 32;
   localparam int ALUOP_W   = 3;
   localparam int RAS_DEPTH = 8;
   localparam int MAX_WAIT  = 15;
   localparam int EW        = 2*PC_W + 6;
   localparam int NV        = 8;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   jump_resolve_unit_if #(.PC_W(PC_W), .DATA_W(DATA_W), .ALUOP_W(ALUOP_W),
                          .RAS_DEPTH(RAS_DEPTH)) bus();

   jump_resolve_unit #(.PC_W(PC_W), .DATA_W(DATA_W), .ALUOP_W(ALUOP_W),
                       .RAS_DEPTH(RAS_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [2:0]  aluop;
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [31:0] rs;
      int          delay;
      logic [25:0] idx;
      logic [31:0] pc4;
      logic [31:0] target;
      logic        link;
      logic        jr;
      logic        jalr;
      logic        mis;
   } vec_t;

   vec_t vecs[NV];

   // scoreboard: {target, link_addr, flush, link, jr, jalr, misaligned, mispredict}
   logic [EW-1:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, want);
   endtask

   task automatic check_pulse(input string tag);
      logic [EW-1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: redirect with empty expected queue, target 0x%0h", tag, bus.o_target);
         return;
      end
      e = exp_q.pop_front();
      check({tag, " target"}, bus.o_target, e[EW-1 -: PC_W]);
      check({tag, " link_addr"}, bus.o_link_addr, e[PC_W+5 -: PC_W]);
      check({tag, " flags"}, {bus.o_flush, bus.o_link, bus.o_JR_Control, bus.o_JALR_Control,
                              bus.o_misaligned, bus.o_mispredict}, e[5:0]);
   endtask

   task automatic idle_inputs();
      bus.i_valid         = 1'b0;
      bus.i_AluOp         = '0;
      bus.i_opcode        = '0;
      bus.i_Function_code = '0;
      bus.i_rs_is_ra      = 1'b0;
      bus.i_rs_value      = '0;
      bus.i_rs_ready      = 1'b0;
      bus.i_jump_index    = '0;
      bus.i_pc_plus4      = '0;
   endtask

   // driver: present one jump, deliver rs after v.delay cycles, check the redirect pulse
   task automatic run_jump(input vec_t v, input string tag);
      int  stalls;
      bit  done;
      @(posedge clk); #1;
      bus.i_valid         = 1'b1;
      bus.i_AluOp         = v.aluop;
      bus.i_opcode        = v.opcode;
      bus.i_Function_code = v.funct;
      bus.i_rs_is_ra      = 1'b0;
      bus.i_jump_index    = v.idx;
      bus.i_pc_plus4      = v.pc4;
      bus.i_rs_ready      = (v.delay == 0);
      bus.i_rs_value      = (v.delay == 0) ? v.rs : $urandom();
      exp_q.push_back({v.target, v.pc4, 1'b1, v.link, v.jr, v.jalr, v.mis, 1'b0});
      stalls = 0;
      done   = 1'b0;
      for (int n = 0; n < 64 && !done; n++) begin
         @(negedge clk);
         if (bus.o_stall) stalls++;
         if (v.delay > MAX_WAIT + 1 && n == MAX_WAIT)
            check({tag, " timeout_before"}, bus.o_timeout, 1'b0);
         if (v.delay > MAX_WAIT + 1 && n == MAX_WAIT + 1)
            check({tag, " timeout_onset"}, bus.o_timeout, 1'b1);
         if (bus.o_target_valid) begin
            check_pulse(tag);
            done = 1'b1;
         end
         @(posedge clk); #1;
         bus.i_valid    = 1'b0;
         bus.i_rs_ready = (n + 1 >= v.delay);
         bus.i_rs_value = (n + 1 == v.delay) ? v.rs : $urandom();
      end
      if (!done) begin
         n_checks++;
         $display("FAIL %s: no redirect within 64 cycles", tag);
      end
      check({tag, " stall_cycles"}, stalls, v.delay + 1);
      bus.i_rs_ready = 1'b0;
   endtask

   task automatic run_ignored(input logic [2:0] aluop, input logic [5:0] opcode,
                              input logic [5:0] funct, input string tag);
      @(posedge clk); #1;
      bus.i_valid         = 1'b1;
      bus.i_AluOp         = aluop;
      bus.i_opcode        = opcode;
      bus.i_Function_code = funct;
      bus.i_rs_ready      = 1'b1;
      bus.i_rs_value      = $urandom();
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         check(tag, {bus.o_stall, bus.o_target_valid, bus.o_flush, bus.dbg_state != IDLE}, 4'b0);
         @(posedge clk); #1;
      end
      idle_inputs();
   endtask

`ifdef JUMP_RAS_EN
   // JR $ra with rs ready at cycle 3: speculative redirect at cycle 1, resolve at cycle 4
   task automatic ras_jr(input logic [31:0] pred, input logic [31:0] rs, input string tag);
      bit hit;
      hit = (rs == pred);
      @(posedge clk); #1;
      bus.i_valid         = 1'b1;
      bus.i_AluOp         = 3'b011;
      bus.i_opcode        = 6'b000000;
      bus.i_Function_code = FN_JR;
      bus.i_rs_is_ra      = 1'b1;
      bus.i_rs_ready      = 1'b0;
      bus.i_rs_value      = $urandom();
      for (int n = 0; n <= 4; n++) begin
         @(negedge clk);
         if (n == 1) begin
            check({tag, " spec_flags"}, {bus.o_target_valid, bus.o_flush, bus.o_stall}, 3'b111);
            check({tag, " spec_target"}, bus.o_target, pred);
         end
         if (n == 4) begin
            check({tag, " resolve_flags"},
                  {bus.o_target_valid, bus.o_flush, bus.o_mispredict, bus.o_stall},
                  hit ? 4'b0000 : 4'b1110);
            if (!hit) check({tag, " corrected_target"}, bus.o_target, rs);
         end
         @(posedge clk); #1;
         bus.i_valid    = 1'b0;
         bus.i_rs_is_ra = 1'b0;
         bus.i_rs_ready = (n + 1 >= 3);
         bus.i_rs_value = (n + 1 == 3) ? rs : $urandom();
      end
      idle_inputs();
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t ras_jal;
      vecs[0] = '{3'b000, OP_J,   6'h00,   32'h0000_0000, 0,  26'h010_0040, 32'h0040_0010,
                  32'h0040_0100, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{3'b000, OP_JAL, 6'h00,   32'h0000_0000, 0,  26'h3FF_FFFF, 32'h0040_0020,
                  32'h0FFF_FFFC, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{3'b011, 6'h00,  FN_JALR, 32'h0000_1003, 3,  26'h000_0000, 32'h0040_0030,
                  32'h0000_1000, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[3] = '{3'b011, 6'h00,  FN_JR,   32'h8000_0004, 0,  26'h000_0000, 32'h0040_0040,
                  32'h8000_0004, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{3'b000, OP_J,   6'h00,   32'h0000_0000, 0,  26'h2AA_AAAA, 32'hF000_0000,
                  32'hFAAA_AAA8, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{3'b011, 6'h00,  FN_JR,   32'hFFFF_FFFE, 1,  26'h000_0000, 32'h0000_0004,
                  32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{3'b011, 6'h00,  FN_JALR, 32'h0000_2001, 0,  26'h000_0000, 32'h1000_0008,
                  32'h0000_2000, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{3'b011, 6'h00,  FN_JR,   32'h0040_1234, 20, 26'h000_0000, 32'h0000_0100,
                  32'h0040_1234, 1'b0, 1'b1, 1'b0, 1'b0};

      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_flags", {bus.o_JR_Control, bus.o_JALR_Control, bus.o_link, bus.o_stall,
                            bus.o_flush, bus.o_target_valid, bus.o_misaligned,
                            bus.o_mispredict, bus.o_timeout}, 9'b0);
      check("reset_data", {bus.o_target, bus.o_link_addr}, 64'h0);
      check("reset_state", bus.dbg_state, IDLE);
      check("reset_ras_count", bus.dbg_ras_count, 0);

      for (int i = 0; i < NV; i++) run_jump(vecs[i], $sformatf("vec%0d", i));
      check("queue_drained", exp_q.size(), 0);

      repeat (2) @(posedge clk);
      @(negedge clk);
      check("timeout_sticky", bus.o_timeout, 1'b1);

      run_ignored(3'b011, 6'h00, 6'h20, "ignore_add");
      run_ignored(3'b000, 6'h08, FN_JR, "ignore_non_rtype_funct");
      run_ignored(3'b000, 6'h23, 6'h09, "ignore_lw");

      // reset asserted while waiting for rs aborts the jump without a pulse
      @(posedge clk); #1;
      bus.i_valid         = 1'b1;
      bus.i_AluOp         = 3'b011;
      bus.i_Function_code = FN_JR;
      bus.i_rs_ready      = 1'b0;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      @(negedge clk);
      check("abort_in_wait", bus.dbg_state, WAIT_RS);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst            = 1'b0;
      bus.i_rs_ready = 1'b1;
      bus.i_rs_value = 32'h0000_4444;
      @(negedge clk);
      check("abort_flags", {bus.o_JR_Control, bus.o_JALR_Control, bus.o_link, bus.o_stall,
                            bus.o_flush, bus.o_target_valid, bus.o_misaligned,
                            bus.o_mispredict, bus.o_timeout}, 9'b0);
      check("abort_data", {bus.o_target, bus.o_link_addr}, 64'h0);
      check("abort_state", bus.dbg_state, IDLE);
      for (int n = 0; n < 4; n++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check($sformatf("abort_quiet%0d", n), {bus.o_target_valid, bus.o_stall}, 2'b00);
      end
      idle_inputs();

`ifdef JUMP_RAS_EN
      ras_jal = '{3'b000, OP_JAL, 6'h00, 32'h0, 0, 26'h000_0040, 32'h0000_0100,
                  32'h0000_0100, 1'b1, 1'b0, 1'b0, 1'b0};
      run_jump(ras_jal, "ras_jal1");
      @(negedge clk);
      check("ras_count_push", bus.dbg_ras_count, 1);
      ras_jr(32'h0000_0100, 32'h0000_0100, "ras_hit");
      @(negedge clk);
      check("ras_count_pop", bus.dbg_ras_count, 0);
      run_jump(ras_jal, "ras_jal2");
      ras_jr(32'h0000_0100, 32'h0000_0200, "ras_miss");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/jump_resolve_unit.md
Name: jump_resolve_unit

Overview:
- Sequential successor to the ID-stage JR/JALR decoder.
- Decodes J, JAL, JR and JALR and computes the registered jump target.
- Stalls the front end while a register-jump source operand is still in flight, and issues a one-cycle flush with the redirect target.
- Optional return-address stack (RAS) predicts JR $ra targets before the operand resolves.

Parameters:
- PC_W, 32, width of PC and target.
- DATA_W, 32, width of rs operand.
- ALUOP_W, 3, width of i_AluOp.
- RAS_DEPTH, 8, RAS entries (power of two, ≥2).
- MAX_WAIT, 15, WAIT_RS cycles before timeout flag.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  instruction present in ID this cycle.
- i_AluOp  in  ALUOP_W  main-control ALU op; 3'b011 = R-type.
- i_opcode  in  6  instruction opcode.
- i_Function_code  in  6  funct field.
- i_rs_is_ra  in  1  rs field == 31.
- i_rs_value  in  DATA_W  forwarded rs value.
- i_rs_ready  in  1  i_rs_value is final.
- i_jump_index  in  26  J-format index.
- i_pc_plus4  in  PC_W  PC+4 of ID instruction.
- o_JR_Control  out  1  resolving JR or JALR.
- o_JALR_Control  out  1  resolving JALR.
- o_link  out  1  JAL/JALR: write o_link_addr to rd/$31.
- o_link_addr  out  PC_W  captured PC+4.
- o_stall  out  1  hold IF/ID.
- o_flush  out  1  squash IF instruction.
- o_target_valid  out  1  redirect PC to o_target (1-cycle pulse).
- o_target  out  PC_W  jump target.
- o_misaligned  out  1  register target[1:0] != 0 (pulse).
- o_mispredict  out  1  RAS prediction was wrong (pulse).
- o_timeout  out  1  sticky: WAIT_RS exceeded MAX_WAIT.

Behaviour:
- Reset: all outputs 0, FSM IDLE, wait counter 0, RAS empty. Reset mid-operation aborts any pending jump; no pulse is emitted.
- Decode, sampled only in IDLE with i_valid:
  - JR = AluOp 3'b011 and funct 001000.
  - JALR = AluOp 3'b011 and funct 001001.
  - J = opcode 000010.
  - JAL = opcode 000011.
  - Anything else is ignored.
- Instruction fields (type, i_pc_plus4, i_jump_index, i_rs_is_ra) are latched on accept.
- FSM states:
  - IDLE: J/JAL, or JR/JALR with i_rs_ready → RESOLVE, o_stall=1 this cycle. JR/JALR without i_rs_ready → WAIT_RS, o_stall=1.
  - WAIT_RS: o_stall=1; counter increments each cycle. When i_rs_ready → RESOLVE. When counter reaches MAX_WAIT, o_timeout is set (sticky until reset) and waiting continues. Counter saturates.
  - RESOLVE (exactly 1 cycle): o_target_valid=1, o_flush=1, o_stall=0. Control flags and o_link/o_link_addr are valid. Next state IDLE; counter cleared.
- Latency: 1 cycle from accept to o_target_valid when the operand is ready; otherwise the WAIT_RS cycle count + 1.
- Target computation:
  - J/JAL: {pc_plus4[PC_W-1:28], index, 2'b00}.
  - JR/JALR: rs_value[PC_W-1:0] with bits [1:0] forced to 0. o_misaligned pulses in RESOLVE if the original bits [1:0] were nonzero.
- rs value is captured in the cycle i_rs_ready is first seen; later changes are ignored.
- o_link=1 for JAL/JALR only; o_link_addr = latched pc_plus4.
- i_valid is ignored outside IDLE; upstream holds the instruction under o_stall.

Optional Feature:
- Macro JUMP_RAS_EN.
- When defined:
  - RAS is circular, RAS_DEPTH entries.
  - JAL/JALR pushes pc_plus4 in RESOLVE. Push when full overwrites the oldest entry; count stays RAS_DEPTH.
  - JR with rs_is_ra and RAS non-empty, entering WAIT_RS: pops the top, emits a speculative o_target_valid+o_flush next cycle (inside WAIT_RS, o_stall stays 1).
  - On resolve: if rs target equals the prediction, RESOLVE emits no redirect (o_target_valid=0, o_flush=0). Otherwise o_mispredict=1 with the corrected redirect.
  - Pop when empty: no prediction; normal behaviour.
  - JALR with rs_is_ra: pop at accept, push at RESOLVE.
- When undefined: no RAS storage; o_mispredict tied 0.

Decomposition:
- Package jump_pkg holds:
  - opcode/funct constants (OP_J, OP_JAL, FN_JR, FN_JALR).
  - ALUOP_RTYPE.
  - jump-type enum {JT_NONE, JT_J, JT_JAL, JT_JR, JT_JALR}.
  - FSM state enum {IDLE, WAIT_RS, RESOLVE}.
- Sub-module return_addr_stack (push/pop/top/empty/full, parametrised depth and width), instantiated only under JUMP_RAS_EN.

Test Plan:
- J, pc_plus4=0x0040_0010, index=0x010_0040 → next cycle o_target=0x0040_0100, o_target_valid=o_flush=1, o_link=0.
- JAL, pc_plus4=0x0040_0020 → o_link=1, o_link_addr=0x0040_0020; RAS count 1 (RAS build).
- JALR, rs_ready low 3 cycles, rs=0x0000_1003 → o_stall high 4 cycles, o_target=0x0000_1000, o_misaligned=1, o_JALR_Control=1.
- JR, rs_ready low 20 cycles with MAX_WAIT=15 → o_timeout set at wait cycle 15 and remains 1; redirect occurs when ready.
- RAS build: JAL at pc_plus4=0x100, then JR $ra not ready → speculative target 0x100. Ready with rs=0x100 → no second redirect. Rerun with rs=0x200 → o_mispredict=1, o_target=0x200.
- Assert i_reset during WAIT_RS → next cycle all outputs 0, IDLE, no o_target_valid pulse.
